gf2m_digit_serial_mult: RTL and testbench



---
 rtl/gf2m_pkg.sv | 41 ++++
 rtl/gf2m_digit_shift_reg.sv | 46 ++++
 rtl/gf2m_digit_serial_mult.sv | 116 +++++++++++
 tb/tb_gf2m_digit_serial_mult.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf2m_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gf2m_pkg
// Description : Shared GF(2^m) constants, FSM state type and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package gf2m_pkg;

  localparam int              GF_M         = 163;
  localparam int              GF_MAX_M     = 571;
  localparam logic [GF_M-1:0] GF_POLY_B163 = 163'hC9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } gf2m_state_e;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  // One multiply-by-x step in a field of degree m; operands live in the low
  // m bits of a GF_MAX_M-wide vector so every field size shares this helper.
  function automatic logic [GF_MAX_M-1:0] gf2m_mulx(
    input logic [GF_MAX_M-1:0] v,
    input logic [GF_MAX_M-1:0] poly,
    input int                  m
  );
    logic [GF_MAX_M-1:0] mask;
    logic [GF_MAX_M-1:0] r;
    logic                msb;
    mask = ~({GF_MAX_M{1'b1}} << m);
    msb  = |(v & (GF_MAX_M'(1) << (m - 1)));
    r    = (v << 1) & mask;
    if (msb) r = r ^ poly;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gf2m_digit_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : gf2m_digit_shift_reg
// Description : Holds rA and exposes rA*x^j mod f for j = 0..D.
// Revision    : 1.0 - initial release
// ============================================================================
module gf2m_digit_shift_reg
  import gf2m_pkg::*;
#(
  parameter int           M    = GF_M,
  parameter int           D    = 4,
  parameter logic [M-1:0] POLY = M'(GF_POLY_B163)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                shift,
  input  logic [M-1:0]        a,
  output logic [D:0][M-1:0]   mult
);

  logic [M-1:0]      r_a;
  logic [D:0][M-1:0] w_mult;

  always_comb begin
    w_mult    = '0;
    w_mult[0] = r_a;
    for (int j = 0; j < D; j++) begin
      w_mult[j+1] = M'(gf2m_mulx(GF_MAX_M'(w_mult[j]), GF_MAX_M'(POLY), M));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0;
    end else if (load) begin
      r_a <= a;
    end else if (shift) begin
      r_a <= w_mult[D];
    end
  end

  assign mult = w_mult;

endmodule
`default_nettype wire

// File: rtl/gf2m_digit_serial_mult.sv
`default_nettype none
// ============================================================================
// Module      : gf2m_digit_serial_mult
// Description : Digit-serial LSB-first GF(2^M) multiplier, Z = A*B mod f(x).
// Revision    : 1.0 - initial release
// ============================================================================
module gf2m_digit_serial_mult
  import gf2m_pkg::*;
#(
  parameter int           M    = GF_M,
  parameter int           D    = 4,
  parameter logic [M-1:0] POLY = M'(GF_POLY_B163)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] z,
  output logic         busy,
  output logic         done
);

  localparam int               c_N     = ceil_div(M, D);
  localparam int               c_CNT_W = $clog2(c_N + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_N - 1);

  gf2m_state_e        r_state;
  gf2m_state_e        w_state_nxt;
  logic [M-1:0]       r_b;
  logic [M-1:0]       r_c;
  logic [c_CNT_W-1:0] r_cnt;
  logic [M-1:0]       w_b_shr;
  logic [M-1:0]       w_acc;
  logic [D:0][M-1:0]  w_mult;
  logic               w_load;
  logic               w_run;
  logic               w_last;
  logic               w_unused_top;

  assign w_load = (r_state == ST_IDLE) && start;
  assign w_run  = (r_state == ST_RUN);
  assign w_last = w_run && (r_cnt == c_LAST);

  gf2m_digit_shift_reg #(
    .M    (M),
    .D    (D),
    .POLY (POLY)
  ) u_shift_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .shift (w_run),
    .a     (a),
    .mult  (w_mult)
  );

  // rA*x^D only feeds the next rA inside the shift register.
  assign w_unused_top = ^w_mult[D];

  always_comb begin
    w_acc = r_c;
    for (int j = 0; j < D; j++) begin
      if (r_b[j]) w_acc = w_acc ^ w_mult[j];
    end
  end

  if (D >= M) begin : g_b_full_digit
    assign w_b_shr = '0;
  end else begin : g_b_partial_digit
    assign w_b_shr = {{D{1'b0}}, r_b[M-1:D]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == ST_RUN);
    done = (r_state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_b   <= '0;
      r_c   <= '0;
      r_cnt <= '0;
      z     <= '0;
    end else if (w_load) begin
      r_b   <= b;
      r_c   <= '0;
      r_cnt <= '0;
    end else if (w_run) begin
      r_b   <= w_b_shr;
      r_c   <= w_acc;
      r_cnt <= r_cnt + c_CNT_W'(1);
      if (w_last) z <= w_acc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gf2m_digit_serial_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_gf2m_digit_serial_mult
// Description : Self-checking bench for several M/D instances of the multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gf2m_digit_serial_mult;

  localparam int NI = 8;
  localparam int CFG_M [NI] = '{163, 163, 163, 163, 4, 4, 4, 4};
  localparam int CFG_D [NI] = '{4, 1, 8, 163, 1, 2, 3, 4};
  localparam logic [162:0] POLY163 = 163'hC9;

  logic         clk = 1'b0;
  logic         s_rst   [NI];
  logic         s_start [NI];
  logic [162:0] s_a     [NI];
  logic [162:0] s_b     [NI];
  logic [162:0] s_z     [NI];
  logic         s_busy  [NI];
  logic         s_done  [NI];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt [NI] = '{default: 0};
  int overlap_cnt = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int MK = CFG_M[k];
    localparam int DK = CFG_D[k];
    localparam logic [MK-1:0] PK = (MK == 163) ? MK'(POLY163) : MK'(3);
    logic [MK-1:0] zl;
    gf2m_digit_serial_mult #(.M(MK), .D(DK), .POLY(PK)) u_dut (
      .clk   (clk),
      .rst   (s_rst[k]),
      .start (s_start[k]),
      .a     (s_a[k][MK-1:0]),
      .b     (s_b[k][MK-1:0]),
      .z     (zl),
      .busy  (s_busy[k]),
      .done  (s_done[k])
    );
    assign s_z[k] = 163'(zl);
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (s_done[k] === 1'b1) done_cnt[k]++;
      if (s_done[k] === 1'b1 && s_busy[k] === 1'b1) overlap_cnt++;
    end
  end

  // Reference: plain MSB-first shift-and-add over the field.
  function automatic logic [162:0] gf_mul(input logic [162:0] x, input logic [162:0] y,
                                          input int m, input logic [162:0] poly);
    logic [162:0] acc, mask, top;
    acc  = '0;
    mask = (163'(1) << m) - 163'(1);
    top  = 163'(1) << (m - 1);
    for (int i = m - 1; i >= 0; i--) begin
      if ((acc & top) != '0) acc = ((acc << 1) & mask) ^ poly;
      else                   acc = (acc << 1) & mask;
      if (y[i]) acc = acc ^ x;
    end
    return acc;
  endfunction

  function automatic logic [162:0] poly_of(input int k);
    return (CFG_M[k] == 163) ? POLY163 : 163'h3;
  endfunction

  function automatic int n_of(input int k);
    return (CFG_M[k] + CFG_D[k] - 1) / CFG_D[k];
  endfunction

  function automatic logic [162:0] rand_val(input int m);
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[162:0] & ((163'(1) << m) - 163'(1));
  endfunction

  // Issue one operation and wait for done; acc = edges until busy, edges = edges until done (-1 on timeout).
  task automatic do_op(input int k, input logic [162:0] av, input logic [162:0] bv,
                       output int acc, output int edges, output bit busy_ok);
    s_a[k] = av; s_b[k] = bv; s_start[k] = 1'b1;
    acc = 0; busy_ok = 1'b1; edges = 0;
    while (acc < 4) begin
      @(posedge clk); #1; acc++;
      if (s_busy[k] === 1'b1) break;
    end
    s_start[k] = 1'b0;
    s_a[k] = rand_val(163); s_b[k] = rand_val(163);
    if (s_busy[k] !== 1'b1) begin
      edges = -1;
      return;
    end
    while (s_done[k] !== 1'b1 && edges < 400) begin
      if (s_busy[k] !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1; edges++;
    end
    if (s_done[k] !== 1'b1) edges = -1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < NI; k++) begin
      s_rst[k] = 1'b1; s_start[k] = 1'b1; s_a[k] = rand_val(CFG_M[k]); s_b[k] = rand_val(CFG_M[k]);
    end
    settle(3);
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (s_z[k] !== '0 || s_busy[k] !== 1'b0 || s_done[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: z=%h busy=%b done=%b, required z=0 busy=0 done=0",
                 k, s_z[k], s_busy[k], s_done[k]);
      end
      s_rst[k] = 1'b0; s_start[k] = 1'b0;
    end
    settle(1);
  endtask

  task automatic test_basic();
    int acc, edges; bit bok;
    do_op(0, 163'd1, 163'd1, acc, edges, bok);
    n_checks++;
    if (acc != 1 || edges != 41) begin
      n_fail++; $display("FAIL basic_latency: accept=%0d run=%0d, required 1 and 41", acc, edges);
    end
    n_checks++;
    if (!bok) begin n_fail++; $display("FAIL basic_busy: busy dropped, required high until done"); end
    n_checks++;
    if (s_z[0] !== 163'd1) begin n_fail++; $display("FAIL basic_z: got %h required 1", s_z[0]); end
    settle(5);
    n_checks++;
    if (s_z[0] !== 163'd1 || s_done[0] !== 1'b0) begin
      n_fail++; $display("FAIL basic_hold: z=%h done=%b, required z=1 done=0", s_z[0], s_done[0]);
    end
  endtask

  task automatic test_reduction();
    int acc, edges; bit bok;
    logic [162:0] hi;
    hi = 163'(1) << 162;
    do_op(0, hi, 163'd2, acc, edges, bok);
    n_checks++;
    if (s_z[0] !== 163'hC9) begin n_fail++; $display("FAIL reduce_x163: got %h required c9", s_z[0]); end
    settle(2);
    do_op(0, 163'd123456789, 163'd0, acc, edges, bok);
    n_checks++;
    if (s_z[0] !== '0) begin n_fail++; $display("FAIL mul_by_zero: got %h required 0", s_z[0]); end
    settle(2);
  endtask

  task automatic test_ignore_start();
    int base;
    logic [162:0] a1, b1, exp;
    base = done_cnt[0];
    a1 = rand_val(163); b1 = rand_val(163);
    exp = gf_mul(a1, b1, 163, POLY163);
    s_a[0] = a1; s_b[0] = b1; s_start[0] = 1'b1;
    settle(1);
    s_start[0] = 1'b0;
    settle(20);
    s_a[0] = rand_val(163); s_b[0] = rand_val(163); s_start[0] = 1'b1;
    settle(1);
    s_start[0] = 1'b0;
    settle(60);
    n_checks++;
    if (s_z[0] !== exp) begin n_fail++; $display("FAIL ignore_start_z: got %h required %h", s_z[0], exp); end
    n_checks++;
    if (done_cnt[0] - base != 1 || s_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL ignore_start_done: dones=%0d busy=%b, required 1 and 0", done_cnt[0] - base, s_busy[0]);
    end
  endtask

  task automatic test_rst_mid_run();
    int acc, edges, base; bit bok;
    logic [162:0] av, bv;
    base = done_cnt[0];
    s_a[0] = rand_val(163); s_b[0] = rand_val(163) | 163'd1; s_start[0] = 1'b1;
    settle(1);
    s_start[0] = 1'b0;
    settle(10);
    s_rst[0] = 1'b1;
    settle(1);
    s_rst[0] = 1'b0;
    n_checks++;
    if (s_busy[0] !== 1'b0 || s_done[0] !== 1'b0 || s_z[0] !== '0) begin
      n_fail++; $display("FAIL rst_mid_run: busy=%b done=%b z=%h, required 0 0 0", s_busy[0], s_done[0], s_z[0]);
    end
    settle(45);
    n_checks++;
    if (done_cnt[0] != base) begin n_fail++; $display("FAIL rst_no_done: dones=%0d required 0", done_cnt[0] - base); end
    av = rand_val(163); bv = rand_val(163);
    do_op(0, av, bv, acc, edges, bok);
    n_checks++;
    if (s_z[0] !== gf_mul(av, bv, 163, POLY163) || edges != 41) begin
      n_fail++; $display("FAIL rst_recover: z=%h run=%0d, required %h and 41", s_z[0], edges, gf_mul(av, bv, 163, POLY163));
    end
    settle(2);
  endtask

  task automatic test_small_field();
    int acc, edges; bit bok;
    logic [162:0] av, bv, exp;
    for (int k = 4; k < 8; k++) begin
      do_op(k, 163'd8, 163'd2, acc, edges, bok);
      n_checks++;
      if (s_z[k] !== 163'd3 || edges != n_of(k)) begin
        n_fail++; $display("FAIL small_x4[D=%0d]: z=%h run=%0d, required 3 and %0d", CFG_D[k], s_z[k], edges, n_of(k));
      end
      for (int i = 0; i < 6; i++) begin
        av = rand_val(4); bv = rand_val(4);
        exp = gf_mul(av, bv, 4, 163'h3);
        do_op(k, av, bv, acc, edges, bok);
        n_checks++;
        if (s_z[k] !== exp) begin
          n_fail++; $display("FAIL small_rand[D=%0d]: %h*%h got %h required %h", CFG_D[k], av, bv, s_z[k], exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc, edges; bit bok;
    logic [162:0] av, bv;
    settle(3);
    for (int i = 0; i < 3; i++) begin
      av = rand_val(163); bv = rand_val(163);
      do_op(0, av, bv, acc, edges, bok);
      n_checks++;
      if (s_z[0] !== gf_mul(av, bv, 163, POLY163)) begin
        n_fail++; $display("FAIL b2b_z[%0d]: got %h required %h", i, s_z[0], gf_mul(av, bv, 163, POLY163));
      end
      if (i > 0) begin
        n_checks++;
        if (acc + edges != 43) begin
          n_fail++; $display("FAIL b2b_period[%0d]: got %0d required 43", i, acc + edges);
        end
      end
    end
    settle(2);
  endtask

  task automatic rand_run(input int k, input int n);
    int acc, edges, base; bit bok;
    logic [162:0] av, bv, exp;
    base = done_cnt[k];
    for (int i = 0; i < n; i++) begin
      av = (i == 0) ? rand_val(163) | ~163'd0 : rand_val(163);
      bv = (i == 0) ? ~163'd0 : rand_val(163);
      exp = gf_mul(av, bv, 163, POLY163);
      do_op(k, av, bv, acc, edges, bok);
      n_checks++;
      if (s_z[k] !== exp) begin
        n_fail++; $display("FAIL rand_z[D=%0d] op %0d: got %h required %h", CFG_D[k], i, s_z[k], exp);
      end
      n_checks++;
      if (edges != n_of(k) || !bok) begin
        n_fail++; $display("FAIL rand_latency[D=%0d] op %0d: run=%0d busy_ok=%0d, required %0d and 1",
                           CFG_D[k], i, edges, bok, n_of(k));
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (done_cnt[k] - base != n) begin
      n_fail++; $display("FAIL rand_done_count[D=%0d]: got %0d required %0d", CFG_D[k], done_cnt[k] - base, n);
    end
  endtask

  task automatic test_random();
    fork
      rand_run(0, 150);
      rand_run(1, 50);
      rand_run(2, 200);
      rand_run(3, 300);
    join
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reduction();
    test_ignore_start();
    test_rst_mid_run();
    test_small_field();
    test_back_to_back();
    test_random();
    n_checks++;
    if (overlap_cnt != 0) begin
      n_fail++; $display("FAIL busy_done_overlap: got %0d cycles required 0", overlap_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
